// File: rtl/instr_dcd_pkg.sv
// Shared types and constants for the SPI instruction decoder.
// Optional build macro: INSTR_DCD_AUTOINC_EN (address auto-increment bursts).
package instr_dcd_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;

  // Instruction byte fields; bits [ADDR_W-1:0] carry the register address.
  localparam int RW_BIT   = 7;
  localparam int RSVD_BIT = 6;

  typedef enum logic {
    IDLE_INSTR = 1'b0,
    DATA       = 1'b1
  } instr_state_e;

endpackage

// File: rtl/instr_decoder_byte_sync_edge.sv
// Rising-edge detector for the byte_sync qualifier from the SPI deserializer.
// A byte is accepted only on the cycle byte_sync goes high, so a held strobe
// counts once. The registered copy resets low, so a strobe already high when
// reset releases is accepted on the first clock.
module byte_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic byte_sync,
  output logic byte_acc
);

  logic byte_sync_q;
  logic byte_sync_d;

  // Next value of the delayed strobe copy.
  always_comb begin
    byte_sync_d = byte_sync;
  end

  // Delayed copy of byte_sync; rst_n is an active-high asynchronous reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      byte_sync_q <= 1'b0;
    end else begin
      byte_sync_q <= byte_sync_d;
    end
  end

  // One-cycle acceptance pulse on the low-to-high transition.
  always_comb begin
    byte_acc = byte_sync & ~byte_sync_q;
  end

endmodule

// File: rtl/instr_decoder.sv
// Byte-level instruction decoder between the SPI byte deserializer and the
// PWM register bank. Splits the byte stream into instruction/data pairs and
// drives address, read/write strobes and write data; returns read data.
//
// Optional build macro: INSTR_DCD_AUTOINC_EN
//   defined     - after each data byte stay in DATA and step addr (wraps),
//                 re-strobing read or write; only reset ends a burst.
//   not defined - exactly one data byte per instruction.
//
// state      | meaning
// IDLE_INSTR | next accepted byte is an instruction (rw, addr)
// DATA       | next accepted byte is write data or a read dummy byte
module instr_decoder #(
  parameter int DATA_W = instr_dcd_pkg::DATA_W_DEF,
  parameter int ADDR_W = instr_dcd_pkg::ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_sync,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_read,
  output logic [DATA_W-1:0] data_write
);

  import instr_dcd_pkg::*;

  logic byte_acc;

  instr_state_e      state_q, state_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [DATA_W-1:0] data_write_q, data_write_d;
  logic              read_q, read_d;
  logic              write_q, write_d;

  byte_sync_edge u_byte_sync_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_sync (byte_sync),
    .byte_acc  (byte_acc)
  );

  // Next-state and registered-output decode; strobes default low each cycle.
  always_comb begin
    state_d      = state_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    data_out_d   = data_out_q;
    data_write_d = data_write_q;
    read_d       = 1'b0;
    write_d      = 1'b0;

    case (state_q)
      IDLE_INSTR: begin
        if (byte_acc) begin
          addr_d  = data_in[ADDR_W-1:0];
          rw_d    = data_in[RW_BIT];
          read_d  = ~data_in[RW_BIT];
          state_d = DATA;
        end
      end

      DATA: begin
        // Read data follows the bank continuously so late updates are seen.
        if (!rw_q) begin
          data_out_d = data_read;
        end
`ifdef INSTR_DCD_AUTOINC_EN
        // Write addresses step one cycle after the strobe so the bank sees
        // the strobe with the address it was meant for.
        if (rw_q && write_q) begin
          addr_d = addr_q + 1'b1;
        end
        if (byte_acc) begin
          if (rw_q) begin
            data_write_d = data_in;
            write_d      = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
            read_d = 1'b1;
          end
        end
`else
        if (byte_acc) begin
          state_d = IDLE_INSTR;
          if (rw_q) begin
            data_write_d = data_in;
            write_d      = 1'b1;
          end
        end
`endif
      end

      default: begin
        state_d = IDLE_INSTR;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction without strobes.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= IDLE_INSTR;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      data_out_q   <= '0;
      data_write_q <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      data_out_q   <= data_out_d;
      data_write_q <= data_write_d;
      read_q       <= read_d;
      write_q      <= write_d;
    end
  end

  assign addr       = addr_q;
  assign data_out   = data_out_q;
  assign data_write = data_write_q;
  assign read       = read_q;
  assign write      = write_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: directed cases plus random byte
// streams, compared against a transaction-level model of the decoder.
// Honours INSTR_DCD_AUTOINC_EN the same way as the design.
module tb_instr_decoder;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              byte_sync = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_read;
  logic [DATA_W-1:0] data_write;

  logic [DATA_W-1:0] regs [64];

  instr_decoder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_sync  (byte_sync),
    .data_in    (data_in),
    .data_out   (data_out),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .data_read  (data_read),
    .data_write (data_write)
  );

  assign data_read = regs[addr];

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Strobe observations made away from the rising edge.
  int rd_cnt = 0;
  int wr_cnt = 0;
  int overlap_cnt = 0;
  int rd_addr = 0;
  int wr_addr = 0;
  int wr_data = 0;

  always @(negedge clk) begin
    if (read) begin
      rd_cnt++;
      rd_addr = int'(addr);
    end
    if (write) begin
      wr_cnt++;
      wr_addr = int'(addr);
      wr_data = int'(data_write);
    end
    if (read && write) overlap_cnt++;
  end

  // Transaction-level model: what the bus should look like after each byte.
  bit m_expect_instr = 1'b1;
  bit m_rw = 1'b0;
  int m_addr = 0;
  int m_dout = 0;
  int m_dwrite = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_and_check(input logic [7:0] b);
    int exp_rd;
    int exp_wr;
    int exp_wr_addr;
    exp_rd = 0;
    exp_wr = 0;
    exp_wr_addr = 0;
    if (m_expect_instr) begin
      m_addr = int'(b) % 64;
      m_rw = b[7];
      m_expect_instr = 1'b0;
      if (!m_rw) begin
        exp_rd = 1;
        m_dout = int'(regs[m_addr]);
      end
    end else if (m_rw) begin
      exp_wr = 1;
      exp_wr_addr = m_addr;
      m_dwrite = int'(b);
`ifdef INSTR_DCD_AUTOINC_EN
      m_addr = (m_addr + 1) % 64;
`else
      m_expect_instr = 1'b1;
`endif
    end else begin
`ifdef INSTR_DCD_AUTOINC_EN
      m_addr = (m_addr + 1) % 64;
      exp_rd = 1;
      m_dout = int'(regs[m_addr]);
`else
      m_expect_instr = 1'b1;
`endif
    end
    check_eq("read_pulses", rd_cnt, exp_rd);
    check_eq("write_pulses", wr_cnt, exp_wr);
    check_eq("addr", int'(addr), m_addr);
    check_eq("data_write", int'(data_write), m_dwrite);
    check_eq("data_out", int'(data_out), m_dout);
    if (exp_rd == 1) check_eq("read_addr", rd_addr, m_addr);
    if (exp_wr == 1) begin
      check_eq("write_addr", wr_addr, exp_wr_addr);
      check_eq("write_data", wr_data, int'(b));
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    rd_cnt = 0;
    wr_cnt = 0;
    @(negedge clk);
    data_in = b;
    byte_sync = 1'b1;
    repeat (hold) @(negedge clk);
    byte_sync = 1'b0;
    data_in = 8'($urandom);
    repeat (2) @(negedge clk);
    model_and_check(b);
  endtask

  // Change the register under a pending read and confirm data_out follows.
  task automatic poke_read_reg(input logic [7:0] v);
    regs[m_addr] = v;
    repeat (2) @(negedge clk);
    if (!m_expect_instr && !m_rw) m_dout = int'(v);
    check_eq("data_out_track", int'(data_out), m_dout);
  endtask

  // Reset for a few cycles, optionally with byte_sync (0x4F) held across it.
  task automatic do_reset(input bit hold_sync);
    @(negedge clk);
    rst_n = 1'b1;
    byte_sync = hold_sync;
    data_in = 8'h4F;
    rd_cnt = 0;
    wr_cnt = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_addr", int'(addr), 0);
    check_eq("rst_data_out", int'(data_out), 0);
    check_eq("rst_data_write", int'(data_write), 0);
    check_eq("rst_strobes", rd_cnt + wr_cnt, 0);
    m_expect_instr = 1'b1;
    m_rw = 1'b0;
    m_addr = 0;
    m_dout = 0;
    m_dwrite = 0;
    rst_n = 1'b0;
    if (hold_sync) begin
      @(negedge clk);
      byte_sync = 1'b0;
      repeat (2) @(negedge clk);
      model_and_check(8'h4F);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) regs[i] = 8'($urandom);
    regs[15] = 8'h11;

    do_reset(1'b0);

    // Read with late data_read change, then dummy byte.
    send_byte(8'h4F, 1);
    poke_read_reg(8'hFF);
    send_byte(8'h3C, 1);

`ifndef INSTR_DCD_AUTOINC_EN
    // Single write; long strobe; reserved bit set.
    send_byte(8'h8F, 1);
    send_byte(8'hAB, 1);
    send_byte(8'h8F, 3);
    send_byte(8'h55, 1);
    send_byte(8'hCF, 2);
    send_byte(8'h12, 1);
`else
    do_reset(1'b0);
    send_byte(8'hBF, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
`endif

    // Abort after instruction; next byte must be an instruction again.
    do_reset(1'b0);
    send_byte(8'h4F, 1);
    do_reset(1'b0);
    send_byte(8'h8F, 1);
    send_byte(8'hAB, 1);

    // byte_sync high as reset releases counts as an instruction.
    do_reset(1'b1);
    send_byte(8'h00, 1);

    for (int n = 0; n < 120; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        do_reset(1'b0);
      end else if (r < 14 && !m_expect_instr && !m_rw) begin
        poke_read_reg(8'($urandom));
      end else begin
        send_byte(8'($urandom), int'($urandom_range(1, 3)));
      end
    end

    check_eq("rd_wr_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_decoder.md
# instr_decoder

Byte-level instruction decoder between the SPI byte deserializer and the PWM register bank. It splits the incoming byte stream into instruction/data pairs, drives address, read and write strobes to the register bank, and returns read data to the SPI shifter. Every byte arrives on `data_in` qualified by `byte_sync`.

## Interface
- `DATA_W`, 8, byte width of the SPI data path.
- `ADDR_W`, 6, register address width, taken from instruction bits [ADDR_W-1:0].
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-high reset. Asserted when 1. The port name is kept for codebase compatibility.
- `byte_sync` input 1: a complete byte is valid on `data_in`. Rising-edge qualified.
- `data_in` input DATA_W: byte from the SPI deserializer.
- `data_out` output DATA_W: byte returned to the SPI serializer (read data).
- `read` output 1: one-cycle read strobe to the register bank.
- `write` output 1: one-cycle write strobe to the register bank.
- `addr` output ADDR_W: register address.
- `data_read` input DATA_W: register bank read data, combinational on `addr`.
- `data_write` output DATA_W: write data to the register bank.

## Operation
- Byte acceptance happens only on a rising edge of `byte_sync`: `byte_sync`=1 while the registered copy `byte_sync_q`=0. Holding `byte_sync` high for several cycles counts as one byte.
- Instruction byte format:
  - bit7: 1 = write, 0 = read.
  - bit6: reserved, ignored.
  - bits[5:0]: address.
- FSM with two states, IDLE_INSTR and DATA.
- In IDLE_INSTR, on an accepted byte:
  - latch `addr` <= data_in[5:0] and `rw` <= data_in[7];
  - go to DATA;
  - if read, pulse `read` for exactly one cycle.
- In DATA with a read operation:
  - every cycle, `data_out` <= `data_read`, so it tracks late changes of `data_read`;
  - the next accepted byte is a dummy: discard it and return to IDLE_INSTR;
  - `data_out` then holds its last value.
- In DATA with a write operation, on an accepted byte:
  - `data_write` <= `data_in`;
  - pulse `write` for one cycle;
  - return to IDLE_INSTR.
- `data_write` holds its value between writes. `addr` holds until the next instruction.
- `read` and `write` are never high at the same time.

## Timing
- All outputs are registered. The strobe or data appears in the cycle after the clock edge that samples the byte_sync rising edge.
- Reset values: state IDLE_INSTR, `byte_sync_q`=0, `addr`=0, `data_out`=0, `data_write`=0, `read`=0, `write`=0.
- Reset mid-transaction aborts it with no strobe. The next accepted byte is an instruction.
- If `byte_sync` is already high when reset deasserts, it counts as a rising edge on the first clock.
- Back-to-back transactions: an instruction byte may be accepted in the cycle immediately after a `write` pulse.

## Configuration
- `INSTR_DCD_AUTOINC_EN` defined: after a data byte, stay in DATA, increment `addr` by 1 (wrapping 63->0), and re-strobe as follows:
  - read op: pulse `read` again;
  - write op: each further byte writes.
  - Only reset ends a burst.
- Not defined: exactly one data byte per instruction, as described in Operation.

## Structure
- Package `instr_dcd_pkg` holds:
  - state enum (IDLE_INSTR, DATA);
  - `RW_BIT`=7, `RSVD_BIT`=6;
  - `ADDR_W`, `DATA_W` defaults.
- One natural sub-module: `byte_sync_edge`, the rising-edge detector on `byte_sync`. The FSM stays in the top level.

## Test plan
- Reset: assert `rst_n`=1 -> all outputs 0 and state IDLE_INSTR. Hold `byte_sync` during reset -> no strobes.
- Read: byte 0x4F -> `addr`=0x0F, `read` high for one cycle. Set `data_read`=0xFF -> `data_out`=0xFF next cycle. Dummy byte -> back to IDLE_INSTR, no `write`.
- Write: byte 0x8F then 0xAB -> `addr`=0x0F, `data_write`=0xAB, `write` high for exactly one cycle.
- Long strobe: `byte_sync` held high for 3 cycles with 0x8F -> exactly one byte accepted. The next single-cycle byte 0x55 writes 0x55.
- Abort: instruction 0x4F, then reset before the data byte -> no further strobes. Next byte 0x8F is decoded as an instruction.
- Reserved bit: 0xCF vs 0x8F -> identical behaviour. With `INSTR_DCD_AUTOINC_EN` defined: write 0xBF, 0x11, 0x22 -> writes at 0x3F then 0x00.
